// File: rtl/hexdisp_bcd_driver.sv
// Eight-digit active-low 7-seg driver: hex nibbles, or decimal via a serial double-dabble engine.
// Latency: hex 1 cycle / decimal 33 cycles after trigger; inputs are ignored while busy, outputs swap atomically.
module hexdisp_bcd_driver #(
    parameter int BLANK_LZ = 1,
    parameter int ITER     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        dec_mode,
    output logic        busy,
    output logic        ovf,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7
);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t           state_q, state_d;
    logic [31:0]      bin_sr_q, bin_sr_d;
    logic [39:0]      bcd_sr_q, bcd_sr_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [31:0]      last_value_q, last_value_d;
    logic             last_mode_q, last_mode_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [7:0][6:0]  seg_q, seg_d;

    logic [39:0]      bcd_adj;
    logic [31:0]      disp;
    logic [7:0][6:0]  seg_new;
    logic             seen;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_sr_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
        end
    end

    // Digit selection and leading-zero blanking, scanned from the top digit down.
    always_comb begin
        disp = last_mode_q ? bcd_sr_q[31:0] : bin_sr_q;
        seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (disp[4*i +: 4] != 4'd0 || i == 0)
                seen = 1'b1;
            seg_new[i] = (seen || BLANK_LZ == 0) ? seg7(disp[4*i +: 4]) : 7'h7F;
        end
    end

    always_comb begin
        state_d      = state_q;
        bin_sr_d     = bin_sr_q;
        bcd_sr_d     = bcd_sr_q;
        cnt_d        = cnt_q;
        last_value_d = last_value_q;
        last_mode_d  = last_mode_q;
        valid_d      = valid_q;
        ovf_d        = ovf_q;
        seg_d        = seg_q;
        case (state_q)
            IDLE: begin
                if (!valid_q || value != last_value_q || dec_mode != last_mode_q) begin
                    bin_sr_d     = value;
                    last_value_d = value;
                    last_mode_d  = dec_mode;
                    bcd_sr_d     = '0;
                    cnt_d        = '0;
                    state_d      = dec_mode ? CONV : LOAD;
                end
            end
            CONV: begin
                {bcd_sr_d, bin_sr_d} = {bcd_adj[38:0], bin_sr_q, 1'b0};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1))
                    state_d = LOAD;
            end
            LOAD: begin
                seg_d   = seg_new;
                ovf_d   = last_mode_q && (bcd_sr_q[39:32] != 8'd0);
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bin_sr_q     <= '0;
            bcd_sr_q     <= '0;
            cnt_q        <= '0;
            last_value_q <= '0;
            last_mode_q  <= 1'b0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
            seg_q        <= {8{7'h7F}};
        end else begin
            state_q      <= state_d;
            bin_sr_q     <= bin_sr_d;
            bcd_sr_q     <= bcd_sr_d;
            cnt_q        <= cnt_d;
            last_value_q <= last_value_d;
            last_mode_q  <= last_mode_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
            seg_q        <= seg_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign ovf  = ovf_q;
    assign hex0 = seg_q[0];
    assign hex1 = seg_q[1];
    assign hex2 = seg_q[2];
    assign hex3 = seg_q[3];
    assign hex4 = seg_q[4];
    assign hex5 = seg_q[5];
    assign hex6 = seg_q[6];
    assign hex7 = seg_q[7];

endmodule

// File: tb/tb_hexdisp_bcd_driver.sv
// Directed bench for hexdisp_bcd_driver; expected displays come from an arithmetic model via a scoreboard.
module tb_hexdisp_bcd_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        dec_mode;
    logic        busy, ovf;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [7:0][6:0] dut_segs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0][6:0] seg;
        logic            ovf;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    logic [7:0][6:0] prev_segs;
    logic            prev_ovf;
    logic [6:0]      tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hexdisp_bcd_driver #(.BLANK_LZ(1), .ITER(32)) dut (
        .clk(clk), .rst(rst), .value(value), .dec_mode(dec_mode),
        .busy(busy), .ovf(ovf),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
    );

    assign dut_segs = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v, input logic m, input int cyc);
        exp_t e;
        longint unsigned x = v;
        int d [8];
        int ms = 0;
        for (int i = 0; i < 8; i++) begin
            d[i] = m ? int'(x % 10) : int'(x & 15);
            x    = m ? x / 10 : x >> 4;
            if (d[i] != 0) ms = i;
        end
        for (int i = 0; i < 8; i++)
            e.seg[i] = (i > ms) ? 7'h7F : tbl[d[i]];
        e.ovf = m && (v > 32'd99999999);
        e.cyc = cyc;
        return e;
    endfunction

    task automatic drive(input logic [31:0] v, input logic m, input int cyc, input bit push);
        value    = v;
        dec_mode = m;
        if (push) sb.push_back(model(v, m, cyc));
    endtask

    // Waits for the conversion in flight to finish, checking hold behaviour while busy.
    task automatic wait_done(input string tag);
        exp_t e;
        int   n = 0;
        int   held_bad = 0;
        bit   done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                if (dut_segs !== prev_segs || ovf !== prev_ovf) held_bad++;
            end else if (n > 0) begin
                done = 1;
            end
        end
        chk({tag, ":done"}, 64'(done), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, ":sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, ":busy_cycles"}, 64'(n), 64'(e.cyc));
        chk({tag, ":held"}, 64'(held_bad), 64'd0);
        chk({tag, ":segs"}, 64'(dut_segs), 64'(e.seg));
        chk({tag, ":ovf"}, 64'(ovf), 64'(e.ovf));
        prev_segs = e.seg;
        prev_ovf  = e.ovf;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        value     = '0;
        dec_mode  = 1'b0;
        prev_segs = {8{7'h7F}};
        prev_ovf  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset:segs", 64'(dut_segs), 64'({8{7'h7F}}));
        chk("reset:busy", 64'(busy), 64'd0);
        chk("reset:ovf", 64'(ovf), 64'd0);

        // 1: zero in hex mode after reset release
        rst = 1'b0;
        drive(32'd0, 1'b0, 1, 1'b1);
        wait_done("zero_hex");

        // 2: hex mode
        drive(32'h1234ABCD, 1'b0, 1, 1'b1);
        wait_done("hex_1234abcd");
        drive(32'h000000A5, 1'b0, 1, 1'b1);
        wait_done("hex_a5");

        // 3: decimal
        drive(32'd12345678, 1'b1, 33, 1'b1);
        wait_done("dec_12345678");

        // 4: blanking and overflow
        drive(32'd305, 1'b1, 33, 1'b1);
        wait_done("dec_305");
        drive(32'd4294967295, 1'b1, 33, 1'b1);
        wait_done("dec_max_ovf");
        drive(32'd4294967295, 1'b0, 1, 1'b1);
        wait_done("mode_switch_hex");

        // 5: input change mid-conversion is deferred
        drive(32'd100, 1'b1, 23, 1'b1);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("dec_100:busy_early", 64'(n), 64'd10);
        drive(32'd7, 1'b1, 33, 1'b1);
        wait_done("dec_100");
        wait_done("dec_7");

        // 6: reset mid-conversion
        drive(32'd999, 1'b1, 33, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset:segs", 64'(dut_segs), 64'({8{7'h7F}}));
        chk("midreset:busy", 64'(busy), 64'd0);
        chk("midreset:ovf", 64'(ovf), 64'd0);
        prev_segs = {8{7'h7F}};
        prev_ovf  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(32'd999, 1'b1, 33));
        wait_done("dec_999_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
